// File: rtl/imm_inst_encoder_pkg.sv
// Shared constants for the RV32 immediate instruction encoder: format selects,
// opcode values and the register-field grouping used to assemble a word.
package imm_inst_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Which register/funct3 fields accompany the immediate; NONE marks an illegal format.
  typedef enum logic [1:0] {
    REGS_RD_RS1  = 2'b00,
    REGS_RS1_RS2 = 2'b01,
    REGS_RD      = 2'b10,
    REGS_NONE    = 2'b11
  } reg_sel_e;

endpackage

// File: rtl/imm_inst_encoder_imm_scatter.sv
// Combinational immediate scatter: places immediate bits at their RV32 instruction
// positions for the selected format and flags out-of-range immediates.
module imm_scatter
  import imm_inst_encoder_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output reg_sel_e    reg_sel,
  output logic        err
);

  always_comb begin
    imm_bits = '0;
    reg_sel  = REGS_NONE;
    err      = 1'b1;
    case (imm_src)
      IMM_I: begin
        imm_bits[31:20] = imm[11:0];
        reg_sel         = REGS_RD_RS1;
        err             = !((&imm[31:11]) || !(|imm[31:11]));
      end
      IMM_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        reg_sel         = REGS_RS1_RS2;
        err             = !((&imm[31:11]) || !(|imm[31:11]));
      end
      IMM_B: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        reg_sel         = REGS_RS1_RS2;
        err             = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      IMM_U: begin
        imm_bits[31:12] = imm[31:12];
        reg_sel         = REGS_RD;
        err             = |imm[11:0];
      end
      IMM_J: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        reg_sel         = REGS_RD;
        err             = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      default: begin
        imm_bits = '0;
        reg_sel  = REGS_NONE;
        err      = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_inst_encoder.sv
// Streaming RV32 instruction encoder: one output register, word-address counter
// and sticky error, feeding an instruction-memory loader.
module imm_inst_encoder
  import imm_inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        imm_src,
  input  logic [31:0]       imm,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky
);

  logic [31:0]       imm_bits;
  reg_sel_e          reg_sel;
  logic              imm_err;
  logic [31:0]       word;
  logic              accept;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] off_q;

  imm_scatter u_scatter (
    .imm_src  (imm_src),
    .imm      (imm),
    .imm_bits (imm_bits),
    .reg_sel  (reg_sel),
    .err      (imm_err)
  );

  always_comb begin
    word = imm_bits | {25'b0, opcode};
    case (reg_sel)
      REGS_RD_RS1: begin
        word[19:15] = rs1;
        word[14:12] = funct3;
        word[11:7]  = rd;
      end
      REGS_RS1_RS2: begin
        word[24:20] = rs2;
        word[19:15] = rs1;
        word[14:12] = funct3;
      end
      REGS_RD:   word[11:7] = rd;
      default:   word = '0;
    endcase
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never drops and payload never changes while waiting for ready.
  // start wins over everything, so no word is taken in a start cycle.
  assign in_ready = !start && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_addr   <= '0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
      base_q     <= '0;
      off_q      <= '0;
    end else if (start) begin
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_addr   <= '0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
      base_q     <= base;
      off_q      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_inst  <= word;
      out_addr  <= base_q + off_q;
      out_err   <= imm_err;
      // Errored words reuse the address so the loader image stays contiguous.
      if (imm_err) err_sticky <= 1'b1;
      else         off_q      <= off_q + ADDR_W'(4);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Self-checking bench for imm_inst_encoder: directed cases plus random traffic
// scored against an arithmetic model of the encoding rules.
module tb_imm_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_sticky;

  imm_inst_encoder #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm_src(imm_src), .imm(imm), .opcode(opcode), .funct3(funct3),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .err_sticky(err_sticky)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // scoreboard: {err, addr, inst} of the word expected in the output register
  logic [64:0] exp_q[$];
  logic [31:0] m_base;
  logic [31:0] m_n;
  logic        m_sticky;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference encoding from the format rules, using signed ranges and shifts
  function automatic logic [32:0] ref_encode(input logic [2:0] src, input logic [31:0] v,
                                             input logic [6:0] op, input logic [2:0] f3,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2);
    int          s;
    logic [31:0] w;
    logic        e;
    s = int'(v);
    w = 32'(op);
    e = 1'b0;
    case (src)
      3'd0: begin
        w |= ((v & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7);
        e = !(s >= -2048 && s <= 2047);
      end
      3'd1: begin
        w |= (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7)
           | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
        e = !(s >= -2048 && s <= 2047);
      end
      3'd2: begin
        w |= (((v >> 12) & 1) << 31) | (((v >> 5) & 32'h3F) << 25)
           | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 1) << 7)
           | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
        e = !(s >= -4096 && s <= 4095) || (v % 2 != 0);
      end
      3'd3: begin
        w |= (v & 32'hFFFFF000) | (32'(d) << 7);
        e = (v % 4096) != 0;
      end
      3'd4: begin
        w |= (((v >> 20) & 1) << 31) | (((v >> 1) & 32'h3FF) << 21)
           | (((v >> 11) & 1) << 20) | (v & 32'h000FF000) | (32'(d) << 7);
        e = !(s >= -(1 << 20) && s <= (1 << 20) - 1) || (v % 2 != 0);
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  // one cycle: drive at the falling edge, check settled outputs, then advance the model
  task automatic tick(input logic st, input logic [31:0] b, input logic iv, input logic ordy,
                      input logic [2:0] src, input logic [31:0] v, input logic [6:0] op,
                      input logic [2:0] f3, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2);
    logic        valid_m;
    logic        rdy_m;
    logic [32:0] enc;
    @(negedge clk);
    start = st; base = b; in_valid = iv; out_ready = ordy;
    imm_src = src; imm = v; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2;
    #1;
    valid_m = (exp_q.size() != 0);
    rdy_m   = !st && (!valid_m || ordy);
    check("out_valid", 32'(out_valid), 32'(valid_m));
    check("in_ready", 32'(in_ready), 32'(rdy_m));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    if (valid_m) begin
      check("out_inst", out_inst, exp_q[0][31:0]);
      check("out_addr", out_addr, exp_q[0][63:32]);
      check("out_err", 32'(out_err), 32'(exp_q[0][64]));
    end
    if (st) begin
      exp_q.delete();
      m_base = b; m_n = 0; m_sticky = 1'b0;
    end else begin
      if (valid_m && ordy) void'(exp_q.pop_front());
      if (iv && rdy_m) begin
        enc = ref_encode(src, v, op, f3, d, s1, s2);
        exp_q.push_back({enc[32], m_base + m_n * 4, enc[31:0]});
        if (enc[32]) m_sticky = 1'b1;
        else         m_n = m_n + 1;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, 32'h0, 1'b0, ordy, 3'd0, 32'h0, 7'h0, 3'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_start(input logic [31:0] b);
    tick(1'b1, b, 1'b0, 1'b1, 3'd0, 32'h0, 7'h0, 3'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic send(input logic ordy, input logic [2:0] src, input logic [31:0] v,
                      input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2);
    tick(1'b0, 32'h0, 1'b1, ordy, src, v, op, f3, d, s1, s2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_inst"}, out_inst, 32'h0);
    check({tag, "_addr"}, out_addr, 32'h0);
    check({tag, "_err"}, 32'(out_err), 32'h0);
    check({tag, "_sticky"}, 32'(err_sticky), 32'h0);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      1:       return 32'($urandom_range(0, 4095)) << 12;
      2:       return 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
      3:       return 32'($urandom_range(0, 16)) + 32'd2040;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; in_valid = 1'b0; out_ready = 1'b1;
    imm_src = '0; imm = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0;
    m_base = '0; m_n = '0; m_sticky = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // first I-type word after start
    do_start(32'h100);
    send(1'b1, 3'd0, 32'd5, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    idle(1'b1);
    check("lit_i_inst", out_inst, 32'h00500093);
    check("lit_i_addr", out_addr, 32'h100);

    // back-to-back S then B
    do_start(32'h100);
    send(1'b1, 3'd1, 32'd8, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2);
    send(1'b1, 3'd2, 32'hFFFFFFFC, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0);
    check("lit_s_inst", out_inst, 32'h0021A423);
    check("lit_s_addr", out_addr, 32'h100);
    idle(1'b1);
    check("lit_b_inst", out_inst, 32'hFE000EE3);
    check("lit_b_addr", out_addr, 32'h104);

    // J and U
    send(1'b1, 3'd4, 32'h800, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0);
    send(1'b1, 3'd3, 32'h12345000, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0);
    check("lit_j_inst", out_inst, 32'h001000EF);
    idle(1'b1);
    check("lit_u_inst", out_inst, 32'h123452B7);

    // range errors and illegal format; the good word after reuses the address
    send(1'b1, 3'd0, 32'd2048, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    send(1'b1, 3'd0, 32'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    check("err_i_flag", 32'(out_err), 32'h1);
    check("err_i_sticky", 32'(err_sticky), 32'h1);
    send(1'b1, 3'd3, 32'h12345001, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0);
    send(1'b1, 3'd5, 32'd4, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    check("err_u_flag", 32'(out_err), 32'h1);
    idle(1'b1);
    check("illegal_flag", 32'(out_err), 32'h1);
    check("illegal_inst", out_inst, 32'h0);
    // boundary values of each range
    send(1'b1, 3'd0, 32'hFFFFF800, 7'h13, 3'd0, 5'd2, 5'd3, 5'd0);
    send(1'b1, 3'd1, 32'd2047, 7'h23, 3'd2, 5'd0, 5'd4, 5'd5);
    send(1'b1, 3'd2, 32'd4094, 7'h63, 3'd1, 5'd0, 5'd6, 5'd7);
    send(1'b1, 3'd2, 32'd4096, 7'h63, 3'd1, 5'd0, 5'd6, 5'd7);
    send(1'b1, 3'd4, 32'hFFF00000, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0);
    send(1'b1, 3'd4, 32'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0);
    idle(1'b1);

    // backpressure: three stalled cycles then release
    do_start(32'h300);
    send(1'b1, 3'd0, 32'd7, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0);
    for (int i = 0; i < 3; i++) send(1'b0, 3'd0, 32'd9, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0);
    send(1'b1, 3'd0, 32'd9, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0);
    idle(1'b1);
    idle(1'b1);

    // start drops a pending word and clears the sticky error
    send(1'b1, 3'd0, 32'd5000, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    send(1'b0, 3'd0, 32'd6, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    do_start(32'h200);
    send(1'b1, 3'd0, 32'd6, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0);
    idle(1'b1);
    check("restart_addr", out_addr, 32'h200);

    // random traffic with occasional restarts and a mid-stream reset
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        send(1'b0, 3'd0, 32'd1, 7'h13, 3'd0, 5'd1, 5'd1, 5'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        m_base = '0; m_n = '0; m_sticky = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        tick(1'b1, $urandom(), 1'($urandom_range(0, 1)), 1'b1, 3'd0, 32'h0, 7'h13,
             3'd0, 5'd0, 5'd0, 5'd0);
      end else begin
        tick(1'b0, 32'h0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 7) == 7 ? $urandom_range(5, 7) : $urandom_range(0, 4)),
             rand_imm(), 7'($urandom()), 3'($urandom()), 5'($urandom()), 5'($urandom()),
             5'($urandom()));
      end
    end
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_inst_encoder.md
# imm_inst_encoder

Streaming RV32 instruction encoder, the inverse of the datapath immediate extender. Accepts an immediate format select, a 32-bit immediate and register/opcode fields. Range-checks the immediate, scatters its bits into the correct instruction positions and emits the 32-bit instruction word with a target word address. It sits in the test/boot path and feeds an instruction-memory loader through a valid/ready handshake.

## Interface
- `ADDR_W`, 32: width of the base and emitted address.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; loads `base`, clears the word counter and `err_sticky`, flushes the output register.
- `base`  in  ADDR_W  start address, sampled on `start`.
- `in_valid` / `in_ready`  in / out  1  input handshake.
- `imm_src`  in  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 are illegal.
- `imm`  in  32  immediate value (sign-extended byte offset, or the full U value).
- `opcode`  in  7  opcode field.
- `funct3`  in  3  funct3 field.
- `rd`, `rs1`, `rs2`  in  5 each  register fields.
- `out_valid` / `out_ready`  out / in  1  output handshake.
- `out_inst`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  word address of `out_inst`.
- `out_err`  out  1  set when this word's immediate or format was illegal.
- `err_sticky`  out  1  set by any errored word; cleared only by `start` or reset.

## Operation
- Field placement, with inst[6:0] = `opcode`:
  - I: inst[31:20]=imm[11:0], rs1, funct3, rd.
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0], rs2, rs1, funct3.
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11], rs2, rs1, funct3.
  - U: inst[31:12]=imm[31:12], rd.
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12], rd.
- Range rules; a violation sets `out_err`:
  - I/S: imm[31:11] is all-equal.
  - B: imm[31:12] is all-equal and imm[0]=0.
  - J: imm[31:20] is all-equal and imm[0]=0.
  - U: imm[11:0]=0.
  - Illegal `imm_src`: always an error, and `out_inst`=0.
- Errored words are still emitted, encoded from the truncated bits, but they do not advance the counter.
- `out_addr` = base + 4·n, where n is the number of non-error words accepted since `start`. It wraps modulo 2^ADDR_W.

## Timing
- Reset values: `out_valid`, `out_err`, `err_sticky` = 0; `out_inst`, `out_addr`, base register and counter = 0.
- Single output register, 1-cycle latency. A word accepted at edge k is presented after edge k.
- `in_ready` = !start && (!out_valid || out_ready). This gives full throughput (one word per cycle) under continuous `out_ready`.
- With `out_valid`=1 and `out_ready`=0, all outputs hold stable; `in_ready`=0.
- `start` has priority: no input is accepted that cycle, and `out_valid`→0 (a pending word is dropped). The new base applies to the next accepted word.
- The counter increments on the accept edge of a non-error word. `err_sticky` sets on the accept edge of an error word.
- Reset mid-stream clears all state immediately; no word is emitted afterwards until a new accept.

## Structure
- The shared package holds:
  - the `imm_src` encodings (IMM_I … IMM_J);
  - the RV32 opcode constants used by the bench;
  - a function, or one sub-module `imm_scatter` (combinational; `imm_src` and `imm` in; scattered bits and range-error out).
- The top level holds the handshake, the output register, the address counter and the sticky error.

## Test plan
- After `start` with base=0x100, I-type imm=5, opcode=0x13, rd=1, rs1=0, f3=0 → `out_inst`=0x00500093, `out_addr`=0x100, `out_err`=0.
- Back-to-back S imm=8, rs2=2, rs1=3, f3=2, op=0x23, then B imm=−4, rs1=rs2=0, f3=0, op=0x63 → 0x0021A423 @0x100, then 0xFE000EE3 @0x104.
- J imm=0x800, rd=1, op=0x6F → 0x001000EF. U imm=0x12345000, rd=5, op=0x37 → 0x123452B7.
- I imm=2048 → `out_err`=1, `err_sticky`=1; the next good word reuses the same address. U imm=0x12345001 → error. `imm_src`=101 → error, `out_inst`=0.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable. Release → no word lost or duplicated.
- Assert `start` (base=0x200) while a word is pending → word dropped, `err_sticky` cleared, next word @0x200. Assert `rst_n`=0 mid-stream → all outputs read 0 asynchronously.
